// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the shared memory port.
// Three requesters (0 = fetch, 1 = load/store, 2 = DMA/debug) compete for a
// single fixed-latency memory. A grant latches the requester's address, write
// data and write enable, then holds them for MEM_LAT cycles. Read data is
// returned with a one-cycle done pulse. Grants are decided only in IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [2:0]        we,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        mux_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wait count loaded at grant; the access completes on the edge where it is 0,
  // which gives exactly MEM_LAT cycles in ACCESS.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [1:0]        last;
  logic [1:0]        last_nxt;
  logic [1:0]        pick_idx;
  logic [2:0]        gnt_nxt;
  logic [2:0]        done_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              busy_nxt;
  logic [1:0]        mux_sel_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_we_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  // Successor of a requester index in the ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ring_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // First set request in order last+1, last+2, last. Only meaningful when
  // at least one request bit is set.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] c0;
    logic [1:0] c1;
    c0 = ring_next(l);
    c1 = ring_next(c0);
    if (r[c0])      return c0;
    else if (r[c1]) return c1;
    else            return l;
  endfunction

  assign pick_idx = rr_pick(req, last);

  // Next-state and next-output decode; everything holds unless changed below.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_nxt      = last;
    gnt_nxt       = gnt;
    done_nxt      = 3'b000;
    rdata_nxt     = rdata;
    busy_nxt      = busy;
    mux_sel_nxt   = mux_sel;
    mem_addr_nxt  = mem_addr;
    mem_we_nxt    = mem_we;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          gnt_nxt     = 3'b001 << pick_idx;
          mux_sel_nxt = pick_idx;
          last_nxt    = pick_idx;
          busy_nxt    = 1'b1;
          cnt_nxt     = CNT_INIT;
          state_nxt   = ACCESS;
          case (pick_idx)
            2'd0: begin
              mem_addr_nxt  = addr0;
              mem_wdata_nxt = wdata0;
              mem_we_nxt    = we[0];
            end
            2'd1: begin
              mem_addr_nxt  = addr1;
              mem_wdata_nxt = wdata1;
              mem_we_nxt    = we[1];
            end
            default: begin
              mem_addr_nxt  = addr2;
              mem_wdata_nxt = wdata2;
              mem_we_nxt    = we[2];
            end
          endcase
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          // Writes leave the previously returned read data untouched.
          if (!mem_we) begin
            rdata_nxt = mem_rdata;
          end
          done_nxt   = gnt;
          gnt_nxt    = 3'b000;
          mem_we_nxt = 1'b0;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt    = 3'b000;
        busy_nxt   = 1'b0;
        mem_we_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 2'd2;
      gnt       <= 3'b000;
      done      <= 3'b000;
      rdata     <= '0;
      busy      <= 1'b0;
      mux_sel   <= 2'b00;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      rdata     <= rdata_nxt;
      busy      <= busy_nxt;
      mux_sel   <= mux_sel_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_we    <= mem_we_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance for the main
// scenarios and a MEM_LAT=1 instance sharing the same requester inputs.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] addr0, addr1, addr2;
  logic [2:0]  we;
  logic [15:0] wdata0, wdata1, wdata2;

  logic [2:0]  gnt, done;
  logic [15:0] rdata;
  logic        busy;
  logic [1:0]  mux_sel;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [2:0]  l_gnt, l_done;
  logic [15:0] l_rdata;
  logic        l_busy;
  logic [1:0]  l_mux_sel;
  logic [11:0] l_mem_addr;
  logic        l_mem_we;
  logic [15:0] l_mem_wdata;
  logic [15:0] l_mem_rdata;

  logic        use_model;
  logic [15:0] fixed_rdata;

  int checks = 0;
  int errors = 0;

  // Memory model: read data is 0xC in the top nibble over the address.
  always_comb mem_rdata   = use_model ? {4'hC, mem_addr} : fixed_rdata;
  always_comb l_mem_rdata = {4'hC, l_mem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .we(we), .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .mux_sel(mux_sel),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .we(we), .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(l_gnt), .done(l_done), .rdata(l_rdata), .busy(l_busy), .mux_sel(l_mux_sel),
    .mem_addr(l_mem_addr), .mem_we(l_mem_we), .mem_wdata(l_mem_wdata), .mem_rdata(l_mem_rdata)
  );

  // One active edge, then return to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    we  = 3'b000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b expected 000", gnt); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rst_done: got %b expected 000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL rst_mem_addr: got %h expected 000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0000", mem_wdata); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
    checks++; if (mux_sel !== 2'b00) begin errors++; $display("FAIL rst_mux_sel: got %b expected 00", mux_sel); end
    checks++; if (l_gnt !== 3'b000 || l_busy !== 1'b0) begin errors++; $display("FAIL rst_lat1: got gnt=%b busy=%b expected 000/0", l_gnt, l_busy); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    use_model   = 1'b0;
    fixed_rdata = 16'h1234;
    req   = 3'b010;
    addr1 = 12'h0A5;
    we    = 3'b000;
    tick();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rd_gnt: got %b expected 010", gnt); end
    checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL rd_mux_sel: got %b expected 01", mux_sel); end
    checks++; if (mem_addr !== 12'h0A5) begin errors++; $display("FAIL rd_mem_addr: got %h expected 0a5", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b expected 1", busy); end
    req = 3'b000;
    tick();
    checks++; if (gnt !== 3'b010 || done !== 3'b000) begin errors++; $display("FAIL rd_e1: got gnt=%b done=%b expected 010/000", gnt, done); end
    tick();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rd_e2_gnt: got %b expected 000", gnt); end
    checks++; if (done !== 3'b010) begin errors++; $display("FAIL rd_e2_done: got %b expected 010", done); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL rd_rdata: got %h expected 1234", rdata); end
    tick();
    checks++; if (done !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rd_e3: got done=%b busy=%b expected 000/0", done, busy); end
    use_model = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0]  ord [0:4];
    logic [2:0]  oh, eg, ed;
    logic [11:0] ea;
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd0; ord[4] = 2'd1;
    addr0 = 12'h100; addr1 = 12'h200; addr2 = 12'h300;
    we  = 3'b000;
    req = 3'b111;
    for (int k = 0; k < 20; k++) begin
      tick();
      oh = 3'b001 << ord[k/4];
      eg = ((k % 4) < 2) ? oh : 3'b000;
      ed = ((k % 4) == 2) ? oh : 3'b000;
      ea = (ord[k/4] == 2'd0) ? 12'h100 : (ord[k/4] == 2'd1) ? 12'h200 : 12'h300;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL cont_gnt[%0d]: got %b expected %b", k, gnt, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL cont_done[%0d]: got %b expected %b", k, done, ed); end
      if ((k % 4) == 0) begin
        checks++; if (mux_sel !== ord[k/4]) begin errors++; $display("FAIL cont_mux_sel[%0d]: got %0d expected %0d", k, mux_sel, ord[k/4]); end
      end
      if ((k % 4) == 2) begin
        checks++; if (rdata !== {4'hC, ea}) begin errors++; $display("FAIL cont_rdata[%0d]: got %h expected %h", k, rdata, {4'hC, ea}); end
      end
      if (k == 17) req = 3'b000;
    end
  endtask

  task automatic test_write();
    req    = 3'b100;
    we     = 3'b100;
    addr2  = 12'hFFF;
    wdata2 = 16'hBEEF;
    tick();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL wr_gnt: got %b expected 100", gnt); end
    checks++; if (mem_addr !== 12'hFFF) begin errors++; $display("FAIL wr_mem_addr: got %h expected fff", mem_addr); end
    checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_mem_wdata: got %h expected beef", mem_wdata); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we_e0: got %b expected 1", mem_we); end
    req = 3'b000;
    we  = 3'b000;
    tick();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we_e1: got %b expected 1", mem_we); end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_e2: got %b expected 0", mem_we); end
    checks++; if (done !== 3'b100) begin errors++; $display("FAIL wr_done: got %b expected 100", done); end
    checks++; if (rdata !== 16'hC200) begin errors++; $display("FAIL wr_rdata_hold: got %h expected c200", rdata); end
    tick();
    checks++; if (done !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL wr_e3: got done=%b busy=%b expected 000/0", done, busy); end
    checks++; if (mux_sel !== 2'b10 || mem_addr !== 12'hFFF) begin errors++; $display("FAIL wr_hold: got sel=%b addr=%h expected 10/fff", mux_sel, mem_addr); end
  endtask

  task automatic test_withdraw();
    req   = 3'b001;
    addr0 = 12'h010;
    we    = 3'b000;
    tick();
    checks++; if (gnt !== 3'b001 || mem_addr !== 12'h010) begin errors++; $display("FAIL wd_grant: got gnt=%b addr=%h expected 001/010", gnt, mem_addr); end
    req   = 3'b000;
    addr0 = 12'h020;
    tick();
    checks++; if (mem_addr !== 12'h010) begin errors++; $display("FAIL wd_addr_stable: got %h expected 010", mem_addr); end
    tick();
    checks++; if (done !== 3'b001) begin errors++; $display("FAIL wd_done: got %b expected 001", done); end
    checks++; if (rdata !== 16'hC010) begin errors++; $display("FAIL wd_rdata: got %h expected c010", rdata); end
    tick();
    tick();
    tick();
    checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL wd_no_regrant: got gnt=%b busy=%b expected 000/0", gnt, busy); end
  endtask

  task automatic test_reset_midop();
    req    = 3'b010;
    we     = 3'b010;
    addr1  = 12'h055;
    wdata1 = 16'h5555;
    tick();
    checks++; if (gnt !== 3'b010 || mem_we !== 1'b1) begin errors++; $display("FAIL rm_pre: got gnt=%b we=%b expected 010/1", gnt, mem_we); end
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rm_gnt: got %b expected 000", gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_mem_we: got %b expected 0", mem_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    req = 3'b000;
    we  = 3'b000;
    tick();
    tick();
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rm_no_done: got %b expected 000", done); end
    rst = 1'b0;
    req = 3'b110;
    tick();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rm_first: got %b expected 010", gnt); end
    tick();
    tick();
    checks++; if (done !== 3'b010 || rdata !== 16'hC055) begin errors++; $display("FAIL rm_done1: got done=%b rdata=%h expected 010/c055", done, rdata); end
    tick();
    tick();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rm_second: got %b expected 100", gnt); end
    req = 3'b000;
    tick();
    tick();
    checks++; if (done !== 3'b100) begin errors++; $display("FAIL rm_done2: got %b expected 100", done); end
    tick();
  endtask

  task automatic test_lat1();
    req   = 3'b001;
    addr0 = 12'h7FF;
    we    = 3'b000;
    tick();
    checks++; if (l_gnt !== 3'b001 || l_mem_addr !== 12'h7FF || l_busy !== 1'b1) begin errors++; $display("FAIL l1_grant: got gnt=%b addr=%h busy=%b expected 001/7ff/1", l_gnt, l_mem_addr, l_busy); end
    tick();
    checks++; if (l_gnt !== 3'b000) begin errors++; $display("FAIL l1_gnt_drop: got %b expected 000", l_gnt); end
    checks++; if (l_done !== 3'b001) begin errors++; $display("FAIL l1_done: got %b expected 001", l_done); end
    checks++; if (l_rdata !== 16'hC7FF) begin errors++; $display("FAIL l1_rdata: got %h expected c7ff", l_rdata); end
    tick();
    checks++; if (l_done !== 3'b000 || l_busy !== 1'b0 || l_gnt !== 3'b000) begin errors++; $display("FAIL l1_idle: got done=%b busy=%b gnt=%b expected 000/0/000", l_done, l_busy, l_gnt); end
    tick();
    checks++; if (l_gnt !== 3'b001) begin errors++; $display("FAIL l1_regrant: got %b expected 001", l_gnt); end
    req = 3'b000;
    tick();
    checks++; if (l_done !== 3'b001) begin errors++; $display("FAIL l1_done2: got %b expected 001", l_done); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    we  = 3'b000;
    addr0 = 12'h000; addr1 = 12'h000; addr2 = 12'h000;
    wdata0 = 16'h0000; wdata1 = 16'h0000; wdata2 = 16'h0000;
    use_model   = 1'b1;
    fixed_rdata = 16'h0000;
    @(negedge clk);
    test_reset();
    test_single_read();
    do_reset();
    test_contention();
    test_write();
    test_withdraw();
    test_reset_midop();
    do_reset();
    test_lat1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the single 12-bit-addressed memory port between three requesters: instruction fetch (0), data load/store (1) and DMA/debug (2).
- Drives the select of the existing 3-to-1 12-bit address mux with mux_sel, and also drives the memory-side address, write-enable and write data.
- Sequences each fixed-latency access and returns read data to the requester with a one-cycle done pulse.

Parameters:
ADDR_W, 12, address width (matches datapath muxes)
DATA_W, 16, memory data width
MEM_LAT, 2, memory access latency in cycles (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  3  per-requester request, bit i = requester i
addr0, addr1, addr2  in  ADDR_W each  requester addresses
we  in  3  per-requester write enable
wdata0, wdata1, wdata2  in  DATA_W each  requester write data
gnt  out  3  one-hot grant; high for the whole access
done  out  3  one-hot, one-cycle completion pulse
rdata  out  DATA_W  read data, valid while done is high
busy  out  1  high when state != IDLE
mux_sel  out  2  00/01/10 = requester 0/1/2; drives the 3-to-1 address mux
mem_addr  out  ADDR_W  latched address to memory
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the address

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cnt=0, gnt=0, done=0, busy=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, rdata=0, mux_sel=00.
  - last-grant pointer=2, so requester 0 has highest priority first.
- FSM states:
  - IDLE: grant decisions are made only here.
  - ACCESS: access in flight.
  - DONE: completion cycle.
- IDLE:
  - If req==000, stay in IDLE; all outputs hold except done=0.
  - Otherwise pick the first set req bit in order last+1, last+2, last (mod 3).
  - At that edge:
    - gnt=onehot(i), mux_sel=i, last=i, busy=1;
    - mem_addr=addr_i, mem_wdata=wdata_i, mem_we=we[i];
    - cnt=MEM_LAT-1; state=ACCESS.
- ACCESS:
  - Latched address, data and we are held stable. Requester inputs are ignored after the grant edge.
  - If cnt!=0, cnt decrements.
  - If cnt==0, at that edge:
    - rdata=mem_rdata if the access was a read, otherwise rdata holds;
    - done=gnt, gnt=0, mem_we=0; state=DONE.
  - Net effect: mem_we is high for exactly MEM_LAT cycles on writes.
- DONE:
  - done is high for this cycle only.
  - Next edge: done=0, busy=0, state=IDLE.
- Throughput and latency:
  - Grant-to-grant period is MEM_LAT+2 cycles.
  - Latency from req sampled to done high is MEM_LAT+1 edges.
- mux_sel holds its last value in IDLE and DONE. mem_addr and mem_wdata also hold.
- A requester dropping req mid-access does not abort the access: it completes and done still pulses. Requesters must treat done as the only completion indication.
- Simultaneous requests are resolved only by the round-robin pointer. A requester that keeps req high is served again only after the other pending requesters.
- Reset asserted mid-ACCESS or mid-DONE aborts the access with no done pulse. After release, arbitration restarts from pointer=2.
- Invariants:
  - gnt and done are each at most one-hot and never overlap.
  - mem_we is never high outside ACCESS.

Test Plan:
1. Single read (MEM_LAT=2): req=010, addr1=0x0A5, memory returns 0x1234.
   -> After edge 0: gnt=010, mux_sel=01, mem_addr=0x0A5, mem_we=0, busy=1.
   -> After edge 2: gnt=000, done=010, rdata=0x1234.
   -> After edge 3: done=000, busy=0.
2. Contention after reset: req=111 held continuously.
   -> Grant order 0,1,2,0,1.
   -> A new gnt every 4 cycles; done pulses follow in the same order.
3. Write: req=100, we=100, addr2=0xFFF, wdata2=0xBEEF.
   -> mem_addr=0xFFF, mem_wdata=0xBEEF, mem_we=1 for exactly 2 cycles.
   -> done=100 pulse; rdata keeps its prior value.
4. Withdrawal and input change: req0 with addr0=0x010; drop req0 and change addr0=0x020 one cycle after the grant.
   -> mem_addr stays 0x010; done=001 still pulses; no further grant to requester 0.
5. Reset mid-op: assert rst during ACCESS.
   -> gnt, mem_we and busy drop to 0 immediately; no done pulse.
   -> Release with req=110: requester 1 is granted first, then requester 2.
6. MEM_LAT=1 build: req=001 read of 0x7FF.
   -> gnt high for 1 cycle, done one edge later with mem_rdata captured.
   -> Grant-to-grant period is 3 cycles.
